// File: rtl/shifter_seq.sv
// shifter_seq: command-driven universal shift register (load, shift, rotate, arithmetic shift)
// Multi-position shifts run one bit per clock under a start/busy/done handshake.
// Optional macro SHIFTER_SEQ_BARREL_EN: complete any shift in the accepting edge instead.
module shifter_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] D,
    input  logic             D_sr,
    input  logic             D_sl,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             is_shift;

    // One step of a shift op; returns {bit shifted out, new register value}
    function automatic logic [WIDTH:0] step(input logic [2:0] o, input logic [WIDTH-1:0] v,
                                            input logic sr, input logic sl);
        case (o)
            3'b010:  step = {v[0], sr, v[WIDTH-1:1]};
            3'b011:  step = {v[WIDTH-1], v[WIDTH-2:0], sl};
            3'b100:  step = {v[0], v[0], v[WIDTH-1:1]};
            3'b101:  step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            3'b110:  step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: step = {1'b0, v};
        endcase
    endfunction

    assign is_shift = (op >= 3'b010) && (op <= 3'b110);

    // State register and datapath registers; clr aborts any command in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            q_q     <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
        end
    end

    // Next state: step the latched op while shifting, otherwise accept a new command
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        q_d     = q_q;
        sout_d  = sout_q;
        if (state_q == SHIFT) begin
            {sout_d, q_d} = step(op_q, q_q, D_sr, D_sl);
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) state_d = DONE;
        end else if (start) begin
            state_d = DONE;
            if (op == 3'b001) begin
                q_d = D;
            end else if (is_shift && amt != '0) begin
`ifdef SHIFTER_SEQ_BARREL_EN
                for (int i = 0; i < 2**AMT_W; i++)
                    if (i < int'(amt)) {sout_d, q_d} = step(op, q_d, D_sr, D_sl);
`else
                state_d = SHIFT;
                cnt_d   = amt;
                op_d    = op;
`endif
            end
        end else begin
            state_d = IDLE;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        Q    = q_q;
        sout = sout_q;
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end
endmodule

// File: tb/tb_shifter_seq.sv
// tb_shifter_seq: scoreboard bench for shifter_seq (WIDTH=8, AMT_W=3)
module tb_shifter_seq;
`ifdef SHIFTER_SEQ_BARREL_EN
    localparam bit BAR = 1'b1;
`else
    localparam bit BAR = 1'b0;
`endif

    logic       clk = 1'b0, clr = 1'b1, start = 1'b0;
    logic [2:0] op = '0, amt = '0;
    logic [7:0] D = '0;
    logic       D_sr = 1'b0, D_sl = 1'b0;
    logic [7:0] Q;
    logic       sout, busy, done;
    int         cyc = 0, n_cmp = 0, n_err = 0;
    logic [7:0] mq = '0;
    logic       ms = 1'b0;

    typedef struct {logic [7:0] q; logic s; int cyc; string tag;} exp_t;
    exp_t sbq[$];
    exp_t me;

    shifter_seq #(.WIDTH(8), .AMT_W(3)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .amt(amt), .D(D),
        .D_sr(D_sr), .D_sl(D_sl), .Q(Q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: apply n single-bit steps, written as whole-word shifts
    function automatic logic [8:0] model(input logic [2:0] o, input int n, input logic [7:0] q,
                                         input logic s, input logic [7:0] d, input logic sr, input logic sl);
        if (o == 3'd1) return {s, d};
        for (int k = 0; k < n; k++)
            case (o)
                3'd2: begin s = q[0]; q = (q >> 1) | (8'(sr) << 7); end
                3'd3: begin s = q[7]; q = (q << 1) | 8'(sl); end
                3'd4: begin s = q[0]; q = (q >> 1) | (q << 7); end
                3'd5: begin s = q[7]; q = (q << 1) | (q >> 7); end
                3'd6: begin s = q[0]; q = 8'($signed(q) >>> 1); end
                default: ;
            endcase
        return {s, q};
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [2:0] a);
        return (!BAR && o >= 3'd2 && o <= 3'd6 && a != 3'd0) ? int'(a) : 0;
    endfunction

    // Called just before the accepting edge, with D_sr/D_sl already driven
    task automatic push_exp(input logic [2:0] o, input logic [2:0] a, input logic [7:0] d, input string tag);
        logic [8:0] r;
        r = model(o, int'(a), mq, ms, d, D_sr, D_sl);
        sbq.push_back('{q: r[7:0], s: r[8], cyc: cyc + 1 + lat_of(o, a), tag: tag});
        mq = r[7:0];
        ms = r[8];
    endtask

    task automatic send(input logic [2:0] o, input logic [2:0] a, input logic [7:0] d, input logic sr,
                        input logic sl, input string tag, input bit wt, input bit push);
        logic [7:0] q0;
        logic       s0;
        logic [8:0] r;
        int         nb;
        @(posedge clk); #1;
        op = o; amt = a; D = d; D_sr = sr; D_sl = sl; start = 1'b1;
        q0 = mq; s0 = ms;
        if (push) push_exp(o, a, d, tag);
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); amt = 3'($urandom); D = 8'($urandom);
        if (wt) begin
            nb = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) break;
                if (busy) begin
                    r = model(o, nb, q0, s0, d, sr, sl);
                    check({tag, "_mid"}, 32'(Q), 32'(r[7:0]));
                    nb++;
                end
            end
            check({tag, "_done_seen"}, 32'(done), 32'd1);
            check({tag, "_busy_cyc"}, nb, lat_of(o, a));
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation
    always @(negedge clk)
        if (done === 1'b1) begin
            if (sbq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                me = sbq.pop_front();
                check({me.tag, "_q"}, 32'(Q), 32'(me.q));
                check({me.tag, "_sout"}, 32'(sout), 32'(me.s));
                check({me.tag, "_lat"}, cyc, me.cyc);
                check({me.tag, "_busy"}, 32'(busy), 32'd0);
            end
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; start = 1'b1; op = 3'd1; D = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_q", 32'(Q), 32'h00);
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        clr = 1'b0; start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_nodone", 32'(done), 32'd0);
        end
        send(3'd1, 3'd0, 8'hA5, 1'b0, 1'b0, "load", 1'b1, 1'b1);
        check("load_a5", 32'(Q), 32'hA5);
        send(3'd2, 3'd3, 8'h00, 1'b1, 1'b0, "shr3", 1'b1, 1'b1);
        check("shr3_q", 32'(Q), 32'hF4);
        check("shr3_sout", 32'(sout), 32'd1);
        send(3'd1, 3'd0, 8'h81, 1'b0, 1'b0, "load81", 1'b1, 1'b1);
        send(3'd5, 3'd2, 8'h00, 1'b0, 1'b0, "rol2", 1'b1, 1'b1);
        check("rol2_q", 32'(Q), 32'h06);
        check("rol2_sout", 32'(sout), 32'd0);
        send(3'd1, 3'd0, 8'h90, 1'b0, 1'b0, "load90", 1'b1, 1'b1);
        send(3'd6, 3'd2, 8'h00, 1'b0, 1'b0, "asr2", 1'b1, 1'b1);
        check("asr2_q", 32'(Q), 32'hE4);
        check("asr2_sout", 32'(sout), 32'd0);
        send(3'd1, 3'd0, 8'h81, 1'b0, 1'b0, "load81b", 1'b1, 1'b1);
        send(3'd4, 3'd7, 8'h00, 1'b0, 1'b0, "ror7", 1'b1, 1'b1);
        check("ror7_q", 32'(Q), 32'h03);
`ifndef SHIFTER_SEQ_BARREL_EN
        send(3'd1, 3'd0, 8'h3C, 1'b0, 1'b0, "load3c", 1'b1, 1'b1);
        send(3'd2, 3'd5, 8'h00, 1'b0, 1'b0, "shr5_ign", 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1; start = 1'b1; op = 3'd1; D = 8'hFF;
        @(posedge clk); #1; start = 1'b0;
        wait_done("shr5_ign");
        repeat (3) @(negedge clk);
        check("shr5_ign_final", 32'(Q), 32'h01);
        send(3'd2, 3'd5, 8'h00, 1'b1, 1'b0, "abort", 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        @(negedge clk);
        check("abort_q", 32'(Q), 32'h00);
        check("abort_busy", 32'(busy), 32'd0);
        mq = '0; ms = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_nodone", 32'(done), 32'd0);
        end
`endif
        send(3'd1, 3'd0, 8'h5A, 1'b0, 1'b0, "load5a", 1'b1, 1'b1);
        send(3'd3, 3'd0, 8'h00, 1'b0, 1'b1, "shl0", 1'b1, 1'b1);
        check("shl0_q", 32'(Q), 32'h5A);
        send(3'd7, 3'd3, 8'h00, 1'b1, 1'b1, "rsv", 1'b1, 1'b1);
        check("rsv_q", 32'(Q), 32'h5A);
        @(posedge clk); #1;
        op = 3'd1; amt = 3'd0; D = 8'hC3; D_sl = 1'b1; start = 1'b1;
        push_exp(3'd1, 3'd0, 8'hC3, "b2b_load");
        @(posedge clk); #1;
        op = 3'd3; amt = 3'd1;
        push_exp(3'd3, 3'd1, 8'h00, "b2b_shl");
        @(posedge clk); #1; start = 1'b0;
        wait_done("b2b_shl");
        check("b2b_q", 32'(Q), 32'h87);
        check("b2b_sout", 32'(sout), 32'd1);
        for (int k = 0; k < 10; k++)
            send(3'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rnd", 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
